// File: rtl/inst_mem_prog.sv
// inst_mem_prog: host-loadable instruction memory.
// A program is streamed in over a valid/ready load port with an auto-incrementing
// write pointer. The fetch port is a registered, one-cycle-latency read that is
// serviced only once a load has completed (RUN state). Reads at or above the
// loaded word count return all-zeros (NOP).
// Optional feature macro: INST_MEM_PARITY_EN adds an even-parity check on load
// words (i_load_parity in, sticky o_load_err out).
module inst_mem_prog #(
    parameter int IW = 10,
    parameter int DW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load_start,
    input  logic          i_load_valid,
    input  logic [DW-1:0] i_load_data,
    input  logic          i_load_last,
    output logic          o_load_ready,
    output logic          o_load_done,
    output logic [IW:0]   o_load_count,
    input  logic          i_fetch_req,
    input  logic [IW-1:0] i_inst_address,
    output logic [DW-1:0] o_inst_out,
    output logic          o_inst_valid
`ifdef INST_MEM_PARITY_EN
    ,
    input  logic          i_load_parity,
    output logic          o_load_err
`endif
);

    localparam int DEPTH = 2 ** IW;
    localparam logic [IW-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Control state
    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_next;
    logic [IW:0]   r_load_count;
    logic [IW:0]   w_load_count_next;
    logic          r_load_done;
    logic          w_load_done_next;

    // Datapath strobes
    logic          w_accept;
    logic          w_fetch_fire;
    logic          w_in_range;

    // Storage and read pipeline. The raw read register carries no reset so the
    // array plus its output register map onto block RAM; a separate reset-able
    // flag forces the visible output to zero after reset or for out-of-range reads.
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;
    logic          r_rd_zero;
    logic          r_inst_valid;

    // Word count includes the word being accepted now; widened by one bit so a
    // full-depth load reports 2**IW without wrapping.
    logic [IW:0]   w_count_on_end;
    assign w_count_on_end = {1'b0, r_ptr} + (IW+1)'(1);

    // Only addresses below the number of loaded words are readable.
    assign w_in_range = ({1'b0, i_inst_address} < r_load_count);

    // State register and load bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_load_count <= '0;
            r_load_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ptr        <= w_ptr_next;
            r_load_count <= w_load_count_next;
            r_load_done  <= w_load_done_next;
        end
    end

    // Next-state, pointer/count update and datapath strobes
    always_comb begin
        w_state_next      = r_state;
        w_ptr_next        = r_ptr;
        w_load_count_next = r_load_count;
        w_load_done_next  = 1'b0;
        w_accept          = 1'b0;
        w_fetch_fire      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Fetches are ignored until a program has been loaded.
                if (i_load_start) begin
                    w_state_next      = ST_LOAD;
                    w_ptr_next        = '0;
                    w_load_count_next = '0;
                end
            end

            ST_LOAD: begin
                if (i_load_start) begin
                    // Restart: any word offered alongside the restart is dropped.
                    w_ptr_next        = '0;
                    w_load_count_next = '0;
                end else if (i_load_valid) begin
                    w_accept = 1'b1;
                    if (i_load_last || (r_ptr == PTR_LAST)) begin
                        // Last word, either flagged or because the array is full.
                        w_state_next      = ST_RUN;
                        w_load_done_next  = 1'b1;
                        w_load_count_next = w_count_on_end;
                        w_ptr_next        = '0;
                    end else begin
                        w_ptr_next = r_ptr + IW'(1);
                    end
                end
            end

            ST_RUN: begin
                // A new load takes priority over a same-cycle fetch.
                if (i_load_start) begin
                    w_state_next      = ST_LOAD;
                    w_ptr_next        = '0;
                    w_load_count_next = '0;
                end else if (i_fetch_req) begin
                    w_fetch_fire = 1'b1;
                end
            end

            default: begin
                w_state_next      = ST_IDLE;
                w_ptr_next        = '0;
                w_load_count_next = '0;
            end
        endcase
    end

    // Memory write port and raw registered read (no reset on purpose)
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_ptr] <= i_load_data;
        end
        if (w_fetch_fire) begin
            r_rd_data <= r_mem[i_inst_address];
        end
    end

    // Fetch result qualifiers: valid strobe and zero-forcing for NOP returns
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst_valid <= 1'b0;
            r_rd_zero    <= 1'b1;
        end else begin
            r_inst_valid <= w_fetch_fire;
            if (w_fetch_fire) begin
                r_rd_zero <= ~w_in_range;
            end
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic r_load_err;

    // Sticky even-parity error over accepted load words; cleared by a new load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load_err <= 1'b0;
        end else if (i_load_start) begin
            r_load_err <= 1'b0;
        end else if (w_accept && (i_load_parity != (^i_load_data))) begin
            r_load_err <= 1'b1;
        end
    end

    assign o_load_err = r_load_err;
`endif

    assign o_load_ready = (r_state == ST_LOAD);
    assign o_load_done  = r_load_done;
    assign o_load_count = r_load_count;
    assign o_inst_out   = r_rd_zero ? '0 : r_rd_data;
    assign o_inst_valid = r_inst_valid;

endmodule

// File: tb/tb_inst_mem_prog.sv
// Testbench for inst_mem_prog (built with IW=3 so full-depth loads are short).
// Fetch results are checked by a scoreboard: the stimulus pushes the expected
// word from a reference model, a monitor pops on every InstValid.
module tb_inst_mem_prog;

    localparam int IW    = 3;
    localparam int DW    = 9;
    localparam int DEPTH = 2 ** IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          load_done;
    logic [IW:0]   load_count;
    logic          fetch_req = 1'b0;
    logic [IW-1:0] inst_address = '0;
    logic [DW-1:0] inst_out;
    logic          inst_valid;
`ifdef INST_MEM_PARITY_EN
    logic          load_parity = 1'b0;
    logic          load_err;
`endif

    inst_mem_prog #(.IW(IW), .DW(DW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_load_start   (load_start),
        .i_load_valid   (load_valid),
        .i_load_data    (load_data),
        .i_load_last    (load_last),
        .o_load_ready   (load_ready),
        .o_load_done    (load_done),
        .o_load_count   (load_count),
        .i_fetch_req    (fetch_req),
        .i_inst_address (inst_address),
        .o_inst_out     (inst_out),
        .o_inst_valid   (inst_valid)
`ifdef INST_MEM_PARITY_EN
        ,
        .i_load_parity  (load_parity),
        .o_load_err     (load_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: program image, loaded length, and last fetched word.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_count = 0;
    logic [DW-1:0] m_last_out = '0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] words_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_read(input int addr);
        return (addr < m_count) ? m_mem[addr] : '0;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return DW'($urandom_range(1, (2 ** DW) - 1));
    endfunction

    // Monitor: one comparison per presented fetch result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && inst_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: got InstValid=1 data=%0h expected no result", inst_out);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (inst_out !== e) begin
                        bad++;
                        $display("FAIL fetch_data: got %0h expected %0h", inst_out, e);
                    end else begin
                        $display("fetch ok data=%0h", inst_out);
                    end
                end
            end
        end
    end

    // Pulse LoadStart (optionally with a same-cycle fetch that must be dropped).
    task automatic start_load(input bit with_fetch);
        load_start   = 1'b1;
        fetch_req    = with_fetch;
        inst_address = IW'($urandom_range(0, DEPTH - 1));
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        m_count    = 0;
        check("start_ready", load_ready, 1);
        check("start_count", load_count, 0);
        check("start_drops_fetch", inst_valid, 0);
        $display("load start fetch=%0d", with_fetch);
    endtask

    // Stream words_q with random idle gaps; expect_end says whether the final
    // word must complete the load.
    task automatic load_words(input bit expect_end, input bit use_last);
        int n;
        n = words_q.size();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = words_q[i];
            load_last  = use_last && (i == n - 1);
`ifdef INST_MEM_PARITY_EN
            load_parity = ^words_q[i];
`endif
            tick();
            m_mem[i] = words_q[i];
            if (expect_end && i == n - 1) begin
                check("done_pulse", load_done, 1);
                check("done_count", load_count, n);
                check("done_ready_drop", load_ready, 0);
            end else begin
                check("no_done", load_done, 0);
            end
            $display("load word %0d data=%0h last=%0d", i, words_q[i], load_last);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (expect_end) begin
            tick();
            check("done_one_cycle", load_done, 0);
            m_count = n;
        end
    endtask

    task automatic fetch(input int addr);
        fetch_req    = 1'b1;
        inst_address = IW'(addr);
        m_last_out   = model_read(addr);
        exp_q.push_back(m_last_out);
        tick();
        fetch_req = 1'b0;
    endtask

    // Fetch outside RUN: no result, output holds.
    task automatic fetch_ignored();
        fetch_req    = 1'b1;
        inst_address = IW'($urandom_range(0, DEPTH - 1));
        tick();
        fetch_req = 1'b0;
        check("ignored_valid", inst_valid, 0);
        check("ignored_hold", inst_out, m_last_out);
        $display("fetch ignored addr=%0d", inst_address);
    endtask

    task automatic fetch_burst(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            bit req;
            int addr;
            req  = ($urandom_range(0, 3) != 0);
            addr = $urandom_range(0, DEPTH - 1);
            fetch_req    = req;
            inst_address = IW'(addr);
            if (req) begin
                m_last_out = model_read(addr);
                exp_q.push_back(m_last_out);
            end
            tick();
            if (!req) begin
                check("idle_valid", inst_valid, 0);
                check("idle_hold", inst_out, m_last_out);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_count", load_count, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_out", inst_out, 0);
        #10 rst = 1'b0;
        tick();
        fetch_ignored();

        // Directed four-word load and back-to-back fetches
        start_load(1'b0);
        words_q = '{9'h001, 9'h0A5, 9'h1FF, 9'h100};
        load_words(1'b1, 1'b1);
        for (int a = 0; a < 4; a++) fetch(a);
        fetch(7);
        tick();

        // Full-depth load with LoadLast never asserted
        start_load(1'b1);
        words_q.delete();
        for (int i = 0; i < DEPTH; i++) words_q.push_back(rand_word());
        load_words(1'b1, 1'b0);
        for (int a = 0; a < DEPTH; a++) fetch(a);
        tick();

        // Restart mid-load: the word offered with LoadStart is dropped
        start_load(1'b0);
        words_q = '{rand_word(), rand_word()};
        load_words(1'b0, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = rand_word();
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("restart_ready", load_ready, 1);
        check("restart_count", load_count, 0);
        words_q = '{rand_word(), rand_word(), rand_word()};
        load_words(1'b1, 1'b1);
        fetch(0);
        fetch(1);
        fetch(2);
        fetch(5);
        fetch(0);
        tick();

        // Asynchronous reset mid-load after five words
        start_load(1'b0);
        check("load_holds_out", inst_out, m_last_out);
        words_q.delete();
        for (int i = 0; i < 5; i++) words_q.push_back(rand_word());
        load_words(1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst_out", inst_out, 0);
        check("arst_valid", inst_valid, 0);
        check("arst_ready", load_ready, 0);
        check("arst_count", load_count, 0);
        m_count    = 0;
        m_last_out = '0;
        #3 rst = 1'b0;
        tick();
        fetch_ignored();
        fetch_ignored();
        // Stale words above the new count stay unreachable
        start_load(1'b0);
        words_q = '{rand_word(), rand_word()};
        load_words(1'b1, 1'b1);
        fetch(3);
        fetch(4);
        fetch(1);
        tick();

`ifdef INST_MEM_PARITY_EN
        start_load(1'b0);
        check("perr_clear0", load_err, 0);
        load_valid  = 1'b1;
        load_data   = 9'h003;
        load_parity = 1'b1;
        load_last   = 1'b1;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        m_mem[0] = 9'h003;
        m_count  = 1;
        check("perr_set", load_err, 1);
        fetch(0);
        tick();
        check("perr_sticky_run", load_err, 1);
        start_load(1'b0);
        check("perr_cleared", load_err, 0);
        words_q = '{rand_word()};
        load_words(1'b1, 1'b1);
`endif

        // Randomised load/fetch rounds
        for (int r = 0; r < 8; r++) begin
            int  n;
            bit  use_last;
            n = $urandom_range(1, DEPTH);
            use_last = (n < DEPTH) ? 1'b1 : bit'($urandom_range(0, 1));
            start_load(bit'($urandom_range(0, 1)));
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back(rand_word());
            load_words(1'b1, use_last);
            fetch_burst(20);
        end

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_prog.md
Name: inst_mem_prog

Overview:
- Parametrised, host-loadable instruction memory; successor to the fixed hard-coded instruction ROM.
- Program is streamed in over a valid/ready load port with an auto-incrementing write pointer.
- Fetch port is a registered, one-cycle-latency read, gated by load state.
- Sits between the test/boot host and the core's fetch stage; the program counter drives InstAddress.

Parameters:
- IW, 10, address width; depth = 2**IW words.
- DW, 9, instruction word width in bits.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- LoadStart  in  1  begin a new program load; pointer resets to 0.
- LoadValid  in  1  LoadData is valid this cycle.
- LoadData  in  DW  instruction word to write.
- LoadLast  in  1  qualifies the final word of the program.
- LoadReady  out  1  high while in LOAD; a word is accepted when LoadValid && LoadReady.
- LoadDone  out  1  one-cycle pulse when a load completes.
- LoadCount  out  IW+1  number of words written by the last load.
- FetchReq  in  1  read request.
- InstAddress  in  IW  fetch address.
- InstOut  out  DW  fetched instruction; registered.
- InstValid  out  1  InstOut is valid for the request made on the previous cycle.

Behaviour:
- Clocking and reset:
  - One clock domain; Reset is asynchronous and active-high.
  - Reset forces: state IDLE, write pointer 0, LoadCount 0, LoadReady 0, LoadDone 0, InstOut 0, InstValid 0.
  - Memory array contents are not reset.
- State machine (IDLE, LOAD, RUN):
  - IDLE: LoadStart -> LOAD. FetchReq is ignored.
  - LOAD:
    - LoadReady=1.
    - Each accepted word writes mem[ptr]=LoadData, then ptr++.
    - Accepted word with LoadLast=1, or accepted word at ptr==2**IW-1 -> RUN, LoadDone=1 for one cycle, LoadCount=ptr+1.
  - RUN: FetchReq serviced. LoadStart -> LOAD.
- Load rules:
  - On entry to LOAD: ptr=0, LoadCount=0.
  - LoadStart asserted while in LOAD restarts at ptr=0. A word offered in the same cycle is dropped.
  - When LoadValid=0, nothing is written and ptr holds.
  - Full-depth load: the word at 2**IW-1 ends the load even if LoadLast=0. LoadCount=2**IW (hence IW+1 bits). No wrap to 0.
- Fetch:
  - FetchReq in RUN at cycle N -> InstOut=mem[InstAddress], InstValid=1 at cycle N+1.
  - Addresses >= LoadCount return all-zeros (NOP) with InstValid=1.
  - No FetchReq, or state is not RUN -> InstValid=0 next cycle; InstOut holds its previous value.
  - Back-to-back requests give one result per cycle; full throughput.
- Simultaneous events:
  - LoadStart and FetchReq in the same cycle in RUN: load wins, fetch dropped, InstValid=0 next cycle.
  - Reset mid-load: returns to IDLE, LoadCount=0. Already-written words persist but are unreachable until a new load completes, because reads above LoadCount return 0.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- With the macro defined:
  - Adds input LoadParity (1) and output LoadErr (1).
  - On each accepted load word, LoadParity is compared to ^LoadData (even parity).
  - A mismatch sets LoadErr sticky high; the word is still written.
  - LoadErr clears on LoadStart or Reset.
- Without the macro: neither port exists and there is no check.

Test Plan:
- Reset, LoadStart, then 4 words 9'h001, 9'h0A5, 9'h1FF, 9'h100 (last). Expect: LoadDone pulse on the 4th acceptance, LoadCount=4. Fetch addresses 0..3 back-to-back -> InstOut follows one cycle later with matching data, InstValid=1 each cycle.
- After the 4-word load, fetch address 7 -> InstOut=0, InstValid=1. FetchReq while in IDLE -> InstValid stays 0.
- IW=3: load 8 words with LoadLast never asserted -> ends at the 8th word, LoadCount=8, LoadDone pulses once, LoadReady drops.
- Mid-load after 2 words: assert LoadStart alongside a valid word -> that word dropped, ptr=0. Load 3 words with last -> LoadCount=3, and address 0 returns the new first word.
- Reset asserted mid-load after 5 words, asynchronously between clock edges -> outputs zero immediately. After release, state is IDLE and fetches produce InstValid=0.
- With INST_MEM_PARITY_EN: LoadData=9'h003 with LoadParity=1 -> LoadErr=1 from the next cycle and stays high through RUN. The next LoadStart clears it.
